// File: rtl/apb_protocol_checker.sv
// Passive APB3 protocol checker: tracks IDLE/SETUP/ACCESS from sampled bus, flags rule breaks
// as registered pulses, sticky flags and a first-violation code, and keeps saturating counters.
module apb_protocol_checker #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NSLV    = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NSLV-1:0]   PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic              clear,
  output logic [5:0]        viol,
  output logic [5:0]        viol_sticky,
  output logic              first_valid,
  output logic [2:0]        first_code,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [CNT_W-1:0]  slverr_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_nxt, wait_inc;
  logic                just_done, just_done_nxt;
  logic [NSLV-1:0]     cap_sel, cap_sel_nxt;
  logic [ADDR_W-1:0]   cap_addr, cap_addr_nxt;
  logic                cap_write, cap_write_nxt;
  logic [DATA_W-1:0]   cap_wdata, cap_wdata_nxt;
  logic [5:0]          viol_nxt;
  logic [2:0]          code_nxt;
  logic                access_eval;
  logic                done;
  logic                ctrl_mismatch;

  assign ctrl_mismatch = (PSEL != cap_sel) || (PADDR != cap_addr) ||
                         (PWRITE != cap_write) || (PWDATA != cap_wdata);
  assign wait_inc = wait_cnt + WAIT_W'(1);

  // Next-state and per-rule violation decode on the sampled bus.
  // The sample evaluated in SETUP state is the first access cycle, so it can complete or wait.
  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    just_done_nxt = just_done;
    cap_sel_nxt   = cap_sel;
    cap_addr_nxt  = cap_addr;
    cap_write_nxt = cap_write;
    cap_wdata_nxt = cap_wdata;
    viol_nxt      = '0;
    access_eval   = 1'b0;
    done          = 1'b0;

    viol_nxt[0] = (PSEL & (PSEL - NSLV'(1))) != '0;

    case (state)
      ST_IDLE: begin
        just_done_nxt = 1'b0;
        if (PENABLE) begin
          if (just_done) viol_nxt[4] = 1'b1;
          else           viol_nxt[1] = 1'b1;
        end else if (|PSEL) begin
          state_nxt     = ST_SETUP;
          cap_sel_nxt   = PSEL;
          cap_addr_nxt  = PADDR;
          cap_write_nxt = PWRITE;
          cap_wdata_nxt = PWDATA;
        end
      end
      ST_SETUP: begin
        if (PENABLE && (PSEL == cap_sel)) begin
          viol_nxt[3] = ctrl_mismatch;
          access_eval = 1'b1;
        end else begin
          viol_nxt[2] = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        viol_nxt[3] = ctrl_mismatch;
        access_eval = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (access_eval) begin
      if (PREADY) begin
        done          = 1'b1;
        just_done_nxt = 1'b1;
        state_nxt     = ST_IDLE;
        wait_nxt      = '0;
      end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
        viol_nxt[5] = 1'b1;
        state_nxt   = ST_IDLE;
        wait_nxt    = '0;
      end else begin
        state_nxt = ST_ACCESS;
        wait_nxt  = wait_inc;
      end
    end
  end

  // Lowest-index violation wins the first-code slot.
  always_comb begin
    code_nxt = '0;
    for (int i = 5; i >= 0; i--) begin
      if (viol_nxt[i]) code_nxt = 3'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      just_done <= 1'b0;
      cap_sel   <= '0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      just_done <= just_done_nxt;
      cap_sel   <= cap_sel_nxt;
      cap_addr  <= cap_addr_nxt;
      cap_write <= cap_write_nxt;
      cap_wdata <= cap_wdata_nxt;
    end
  end

  // Reporting registers; clear reloads from this cycle's events only.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      viol        <= '0;
      viol_sticky <= '0;
      first_valid <= 1'b0;
      first_code  <= '0;
      xfer_cnt    <= '0;
      viol_cnt    <= '0;
      slverr_cnt  <= '0;
    end else begin
      viol <= viol_nxt;
      if (clear) begin
        viol_sticky <= viol_nxt;
        viol_cnt    <= CNT_W'(|viol_nxt);
        first_valid <= |viol_nxt;
        first_code  <= code_nxt;
        xfer_cnt    <= CNT_W'(done);
        slverr_cnt  <= CNT_W'(done && PSLVERR);
      end else begin
        viol_sticky <= viol_sticky | viol_nxt;
        if ((|viol_nxt) && (viol_cnt != CNT_MAX)) viol_cnt <= viol_cnt + CNT_W'(1);
        if ((|viol_nxt) && !first_valid) begin
          first_valid <= 1'b1;
          first_code  <= code_nxt;
        end
        if (done && (xfer_cnt != CNT_MAX)) xfer_cnt <= xfer_cnt + CNT_W'(1);
        if (done && PSLVERR && (slverr_cnt != CNT_MAX)) slverr_cnt <= slverr_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Scoreboard bench for apb_protocol_checker: directed bus cycles push expected checker state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_apb_protocol_checker;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NSLV    = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [NSLV-1:0]   PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              clear;
  logic [5:0]        viol;
  logic [5:0]        viol_sticky;
  logic              first_valid;
  logic [2:0]        first_code;
  logic [CNT_W-1:0]  xfer_cnt;
  logic [CNT_W-1:0]  viol_cnt;
  logic [CNT_W-1:0]  slverr_cnt;

  apb_protocol_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .clear(clear),
    .viol(viol), .viol_sticky(viol_sticky), .first_valid(first_valid), .first_code(first_code),
    .xfer_cnt(xfer_cnt), .viol_cnt(viol_cnt), .slverr_cnt(slverr_cnt)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string            name;
    logic [5:0]       viol;
    logic [5:0]       sticky;
    logic             fv;
    logic [2:0]       fc;
    logic [CNT_W-1:0] xfer;
    logic [CNT_W-1:0] vcnt;
    logic [CNT_W-1:0] serr;
    int               cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge PCLK) cyc_cnt <= cyc_cnt + 1;

  // Monitor: outputs after edge N are compared at the following negedge.
  always @(negedge PCLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc_cnt || viol !== e.viol || viol_sticky !== e.sticky ||
          first_valid !== e.fv || first_code !== e.fc || xfer_cnt !== e.xfer ||
          viol_cnt !== e.vcnt || slverr_cnt !== e.serr) begin
        errors++;
        $display("FAIL %s @cyc %0d: got viol=%b sticky=%b fv=%b fc=%0d xfer=%0d vcnt=%0d serr=%0d | exp viol=%b sticky=%b fv=%b fc=%0d xfer=%0d vcnt=%0d serr=%0d",
                 e.name, cyc_cnt, viol, viol_sticky, first_valid, first_code, xfer_cnt,
                 viol_cnt, slverr_cnt, e.viol, e.sticky, e.fv, e.fc, e.xfer, e.vcnt, e.serr);
      end
    end
  end

  task automatic drive(input logic [1:0] sel, input logic en, input logic wr,
                       input logic [8:0] addr, input logic [7:0] wd,
                       input logic rdy, input logic err, input logic clr);
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wd;
    PREADY = rdy; PSLVERR = err; clear = clr;
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input logic clr);
    drive(2'b00, 1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, clr);
  endtask

  task automatic exp_push(input string name, input logic [5:0] v, input logic [5:0] s,
                          input logic fv, input logic [2:0] fc, input int x,
                          input int vc, input int se);
    exp_t t;
    t.name = name; t.viol = v; t.sticky = s; t.fv = fv; t.fc = fc;
    t.xfer = CNT_W'(x); t.vcnt = CNT_W'(vc); t.serr = CNT_W'(se); t.cyc = cyc_cnt;
    q.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    PSEL = '0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    PREADY = 0; PSLVERR = 0; clear = 0;
    idle(1'b0);
    idle(1'b0);
    exp_push("reset", 6'b0, 6'b0, 0, 0, 0, 0, 0);
    PRESET = 1'b0;

    // Clean write with two wait states
    drive(2'b01, 0, 1, 9'h1A5, 8'h3C, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h1A5, 8'h3C, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h1A5, 8'h3C, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h1A5, 8'h3C, 1, 0, 0);
    exp_push("wr_done", 6'b0, 6'b0, 0, 0, 1, 0, 0);
    idle(0);
    exp_push("wr_idle", 6'b0, 6'b0, 0, 0, 1, 0, 0);

    // Multi-hot PSEL; the abandoned SETUP then breaks R2
    drive(2'b11, 0, 0, 9'h000, 8'h00, 0, 0, 0);
    exp_push("r0_pulse", 6'b000001, 6'b000001, 1, 0, 1, 1, 0);
    idle(0);
    exp_push("r2_after_r0", 6'b000100, 6'b000101, 1, 0, 1, 2, 0);
    idle(1);
    exp_push("clear1", 6'b0, 6'b0, 0, 0, 0, 0, 0);

    // Address changes in the completing ACCESS cycle
    drive(2'b01, 0, 1, 9'h010, 8'h55, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h010, 8'h55, 0, 0, 0);
    exp_push("r3_pre", 6'b0, 6'b0, 0, 0, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h011, 8'h55, 1, 0, 0);
    exp_push("r3_flag", 6'b001000, 6'b001000, 1, 3, 1, 1, 0);
    idle(0);
    exp_push("r3_idle", 6'b0, 6'b001000, 1, 3, 1, 1, 0);
    idle(1);

    // Timeout after 16 ACCESS cycles with PREADY low
    drive(2'b10, 0, 0, 9'h020, 8'h00, 0, 0, 0);
    repeat (15) drive(2'b10, 1, 0, 9'h020, 8'h00, 0, 0, 0);
    exp_push("to_pre", 6'b0, 6'b0, 0, 0, 0, 0, 0);
    drive(2'b10, 1, 0, 9'h020, 8'h00, 0, 0, 0);
    exp_push("to_flag", 6'b100000, 6'b100000, 1, 5, 0, 1, 0);
    idle(0);
    exp_push("to_once", 6'b0, 6'b100000, 1, 5, 0, 1, 0);
    drive(2'b01, 0, 0, 9'h030, 8'h00, 0, 0, 0);
    drive(2'b01, 1, 0, 9'h030, 8'h00, 1, 0, 0);
    exp_push("after_to", 6'b0, 6'b100000, 1, 5, 1, 1, 0);
    idle(1);

    // PENABLE held after completion: R4, not R1
    drive(2'b01, 0, 1, 9'h040, 8'hA0, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h040, 8'hA0, 1, 0, 0);
    exp_push("zw_done", 6'b0, 6'b0, 0, 0, 1, 0, 0);
    drive(2'b01, 1, 1, 9'h040, 8'hA0, 0, 0, 0);
    exp_push("r4_only", 6'b010000, 6'b010000, 1, 4, 1, 1, 0);
    idle(0);
    idle(1);
    exp_push("clear2", 6'b0, 6'b0, 0, 0, 0, 0, 0);

    // Read with PSLVERR, then back-to-back transfers into saturation
    drive(2'b01, 0, 0, 9'h050, 8'h00, 0, 0, 0);
    drive(2'b01, 1, 0, 9'h050, 8'h00, 1, 1, 0);
    exp_push("slverr", 6'b0, 6'b0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 19; i++) begin
      drive(2'b01, 0, 0, 9'(i), 8'h00, 0, 0, 0);
      drive(2'b01, 1, 0, 9'(i), 8'h00, 1, 0, 0);
      if (i == 13) exp_push("sat_reach", 6'b0, 6'b0, 0, 0, 15, 0, 1);
    end
    exp_push("sat_hold", 6'b0, 6'b0, 0, 0, 15, 0, 1);

    // Reset in the middle of a transfer
    drive(2'b01, 0, 1, 9'h060, 8'h01, 0, 0, 0);
    drive(2'b01, 1, 1, 9'h060, 8'h01, 0, 0, 0);
    PRESET = 1'b1;
    idle(0);
    exp_push("reset_mid", 6'b0, 6'b0, 0, 0, 0, 0, 0);
    PRESET = 1'b0;
    idle(0);
    exp_push("post_reset", 6'b0, 6'b0, 0, 0, 0, 0, 0);

    // Simultaneous rules, then clear coinciding with a new violation
    drive(2'b11, 1, 0, 9'h000, 8'h00, 0, 0, 0);
    exp_push("r0_r1", 6'b000011, 6'b000011, 1, 0, 0, 1, 0);
    drive(2'b11, 0, 0, 9'h000, 8'h00, 0, 0, 1);
    exp_push("clr_w_viol", 6'b000001, 6'b000001, 1, 0, 0, 1, 0);
    idle(0);
    exp_push("r2_post_clr", 6'b000100, 6'b000101, 1, 0, 0, 2, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge PCLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
